fb_access_arbiter: RTL and testbench

Arbitrates a single-port synchronous frame-buffer RAM (160x120, 12-bit RGB, upscaled 4x to 640x480) between VGA scanout and two game-logic writers (writer 0 = fighter renderer, writer 1 = HUD).
- Scanout reads always win their slot.
- Writers share the remaining cycles round-robin via req/ack.
- Sits between hvsync_generator timing and the vgaR/G/B pins; runs on the 100 MHz system clock with a 1-in-4 pixel enable.

---
 rtl/fb_access_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - Frame-buffer RAM arbiter: VGA scanout reads win, two writers share the rest round-robin.
// Optional tear-free mode: define FB_WR_VBLANK_ONLY_EN to grant writes only while CounterY >= 480.
module fb_access_arbiter #(
    parameter int H_RES       = 160,
    parameter int V_RES       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic              inDisplayArea,
    input  logic [9:0]        CounterX,
    input  logic [9:0]        CounterY,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [11:0]       wr_data0,
    input  logic [11:0]       wr_data1,
    output logic [1:0]        wr_ack,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic [11:0]       rgb,
    output logic              frame_start
);

    localparam int               FB_SIZE  = H_RES * V_RES;
    localparam logic [ADDR_W:0]  FB_LIMIT = (ADDR_W+1)'(FB_SIZE);

    // Constant multiply by H_RES built from shifted adds of the row index.
    function automatic logic [ADDR_W-1:0] times_h_res(input logic [ADDR_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (((H_RES >> b) & 1) != 0) begin
                acc = acc + (y << b);
            end
        end
        return acc;
    endfunction

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [11:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              last_q, last_d;
    logic [1:0]        pix_v_q, pix_v_d;
    logic [1:0]        disp_q, disp_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              frame_start_q, frame_start_d;

    logic              scan_slot;
    logic              wr_window;
    logic [ADDR_W-1:0] scan_row;
    logic [ADDR_W-1:0] scan_col;
    logic [ADDR_W-1:0] scan_addr;
    logic              gnt_valid;
    logic              gnt_sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [11:0]       sel_data;

`ifdef FB_WR_VBLANK_ONLY_EN
    assign wr_window = (CounterY >= 10'd480);
`else
    assign wr_window = 1'b1;
`endif

    assign scan_slot = pix_en & inDisplayArea;
    assign scan_row  = ADDR_W'(CounterY >> SCALE_SHIFT);
    assign scan_col  = ADDR_W'(CounterX >> SCALE_SHIFT);
    assign scan_addr = times_h_res(scan_row) + scan_col;

    // Round-robin: on contention the writer not granted last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        if (!scan_slot && wr_window) begin
            case (wr_req)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b1;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_sel   = ~last_q;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt_sel   = 1'b0;
                end
            endcase
        end
    end

    assign sel_addr = gnt_sel ? wr_addr1 : wr_addr0;
    assign sel_data = gnt_sel ? wr_data1 : wr_data0;

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 2'b00;
        wr_err_d    = 1'b0;
        last_d      = last_q;
        if (scan_slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = scan_addr;
        end else if (gnt_valid) begin
            last_d   = gnt_sel;
            wr_ack_d = gnt_sel ? 2'b10 : 2'b01;
            // Out-of-range writes are still acked so the writer moves on; the RAM is left untouched.
            if ({1'b0, sel_addr} < FB_LIMIT) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sel_addr;
                mem_wdata_d = sel_data;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Pixel pipeline: command at T+1, RAM data at T+2, rgb visible at T+3.
    always_comb begin
        pix_v_d       = {pix_v_q[0], pix_en};
        disp_d        = {disp_q[0], inDisplayArea};
        rgb_d         = rgb_q;
        frame_start_d = pix_en && (CounterX == 10'd0) && (CounterY == 10'd0);
        if (pix_v_q[1]) begin
            rgb_d = disp_q[1] ? mem_rdata : 12'h000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wr_ack_q      <= 2'b00;
            wr_err_q      <= 1'b0;
            last_q        <= 1'b1;
            pix_v_q       <= 2'b00;
            disp_q        <= 2'b00;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wr_ack_q      <= wr_ack_d;
            wr_err_q      <= wr_err_d;
            last_q        <= last_d;
            pix_v_q       <= pix_v_d;
            disp_q        <= disp_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_ack      = wr_ack_q;
    assign wr_err      = wr_err_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - Scoreboard bench for fb_access_arbiter with a synchronous RAM model.
module tb_fb_access_arbiter;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pix_en;
    logic              inDisplayArea;
    logic [9:0]        CounterX;
    logic [9:0]        CounterY;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [11:0]       wr_data0;
    logic [11:0]       wr_data1;
    logic [1:0]        wr_ack;
    logic              wr_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata;
    logic [11:0]       mem_rdata = 12'h000;
    logic [11:0]       rgb;
    logic              frame_start;

    always #5 clk = ~clk;

    fb_access_arbiter dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .inDisplayArea(inDisplayArea),
        .CounterX(CounterX), .CounterY(CounterY), .wr_req(wr_req),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_ack(wr_ack), .wr_err(wr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rgb(rgb), .frame_start(frame_start)
    );

    logic [11:0] ram [0:32767];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct { int cyc; int addr; int data; } mem_exp_t;
    typedef struct { int cyc; int v; } val_exp_t;

    mem_exp_t exp_wr_q[$];
    mem_exp_t exp_rd_q[$];
    val_exp_t exp_ack_q[$];
    val_exp_t exp_rgb_q[$];
    int       exp_fs_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: addr %0d wdata 0x%0h ack %b err %b fs %b at cycle %0d, nothing expected",
                 name, mem_addr, mem_wdata, wr_ack, wr_err, frame_start, cyc);
    endtask

    function automatic void push_wr(input int c, input int a, input int d);
        mem_exp_t e;
        e.cyc = c; e.addr = a; e.data = d;
        exp_wr_q.push_back(e);
    endfunction

    function automatic void push_rd(input int c, input int a);
        mem_exp_t e;
        e.cyc = c; e.addr = a; e.data = 0;
        exp_rd_q.push_back(e);
    endfunction

    // v = {wr_ack, wr_err}
    function automatic void push_ack(input int c, input int v);
        val_exp_t e;
        e.cyc = c; e.v = v;
        exp_ack_q.push_back(e);
    endfunction

    function automatic void push_rgb(input int c, input int v);
        val_exp_t e;
        e.cyc = c; e.v = v;
        exp_rgb_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            mem_exp_t m;
            val_exp_t v;
            if (mem_we) check("we_implies_en", int'(mem_en), 1);
            if (mem_en && mem_we) begin
                if (exp_wr_q.size() == 0) unexpected("unexpected_write");
                else begin
                    m = exp_wr_q.pop_front();
                    check("write_cycle", cyc, m.cyc);
                    check("write_addr", int'(mem_addr), m.addr);
                    check("write_data", int'(mem_wdata), m.data);
                end
            end
            if (mem_en && !mem_we) begin
                if (exp_rd_q.size() == 0) unexpected("unexpected_read");
                else begin
                    m = exp_rd_q.pop_front();
                    check("read_cycle", cyc, m.cyc);
                    check("read_addr", int'(mem_addr), m.addr);
                end
            end
            if (wr_ack != 2'b00 || wr_err) begin
                if (exp_ack_q.size() == 0) unexpected("unexpected_ack");
                else begin
                    v = exp_ack_q.pop_front();
                    check("ack_cycle", cyc, v.cyc);
                    check("ack_err_value", int'({wr_ack, wr_err}), v.v);
                end
            end
            if (frame_start) begin
                if (exp_fs_q.size() == 0) unexpected("unexpected_frame_start");
                else check("frame_start_cycle", cyc, exp_fs_q.pop_front());
            end
            if (exp_rgb_q.size() != 0 && exp_rgb_q[0].cyc == cyc) begin
                v = exp_rgb_q.pop_front();
                check("rgb", int'(rgb), v.v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n, t, b;
`ifdef FB_WR_VBLANK_ONLY_EN
    int v0;
`else
    int c, d, e, f;
`endif

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 12'h000;
        ram[161]   = 12'hABC;
        ram[19199] = 12'h5A5;
        ram[2]     = 12'h123;
        ram[0]     = 12'h0F0;

        reset_n = 1'b0; pix_en = 1'b0; inDisplayArea = 1'b1;
        CounterX = 10'd0; CounterY = 10'd0; wr_req = 2'b11;
        wr_addr0 = 15'd10; wr_addr1 = 15'd20; wr_data0 = 12'h011; wr_data1 = 12'h022;

        for (int i = 0; i < 6; i++) begin
            step();
            pix_en = ~pix_en;
            @(negedge clk);
            check("reset_mem_outputs", int'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
            check("reset_pix_ack_outputs", int'({rgb, wr_ack, wr_err, frame_start}), 0);
        end

        // Release with both writers requesting: writer 0 first, then strict alternation.
        step();
        pix_en = 1'b0; inDisplayArea = 1'b0; CounterY = 10'd480;
        reset_n = 1'b1; mon_on = 1'b1;
        n = cyc;
        for (int k = 0; k < 8; k++) begin
            wr_addr0 = ADDR_W'(100 + (k + 1) / 2); wr_data0 = 12'(12'h100 + (k + 1) / 2);
            wr_addr1 = ADDR_W'(200 + k / 2);       wr_data1 = 12'(12'h200 + k / 2);
            if (k % 2 == 0) begin
                push_ack(n + k + 1, 3'b010);
                push_wr(n + k + 1, 100 + k / 2, 12'h100 + k / 2);
            end else begin
                push_ack(n + k + 1, 3'b100);
                push_wr(n + k + 1, 200 + (k - 1) / 2, 12'h200 + (k - 1) / 2);
            end
            step();
        end
        wr_req = 2'b00;
        step(); step();

        // Scanout: (4,4) -> 1*160+1 = 161; (639,479) -> 119*160+159 = 19199.
        CounterX = 10'd4; CounterY = 10'd4; inDisplayArea = 1'b1; pix_en = 1'b1;
        t = cyc;
        push_rd(t + 1, 161); push_rgb(t + 3, 12'hABC); push_rgb(t + 4, 12'hABC);
        step(); pix_en = 1'b0;
        step(); step(); step(); step();
        CounterX = 10'd639; CounterY = 10'd479; pix_en = 1'b1;
        t = cyc;
        push_rd(t + 1, 19199); push_rgb(t + 3, 12'h5A5);
        step(); pix_en = 1'b0;
        step(); step(); step();

        // Blanking: pixel slot outside the display area forces rgb to 0.
        inDisplayArea = 1'b0; pix_en = 1'b1;
        b = cyc;
        push_rgb(b + 3, 0);
        step(); pix_en = 1'b0;
        step(); step(); step(); step();

`ifdef FB_WR_VBLANK_ONLY_EN
        CounterY = 10'd100; wr_req = 2'b01; wr_addr0 = 15'd700; wr_data0 = 12'h700;
        v0 = cyc;
        step(); step(); step(); step();
        CounterY = 10'd480;
        push_ack(v0 + 5, 3'b010); push_wr(v0 + 5, 700, 12'h700);
        step();
        wr_req = 2'b00;
        step(); step();
`else
        // Collision: write to the scanned address waits one cycle; the read sees the old pixel.
        CounterX = 10'd8; CounterY = 10'd0; inDisplayArea = 1'b1; pix_en = 1'b1;
        wr_req = 2'b01; wr_addr0 = 15'd2; wr_data0 = 12'hFED;
        c = cyc;
        push_rd(c + 1, 2); push_ack(c + 2, 3'b010); push_wr(c + 2, 2, 12'hFED); push_rgb(c + 3, 12'h123);
        step(); pix_en = 1'b0;
        step(); wr_req = 2'b00;
        step();
        step(); pix_en = 1'b1;
        push_rd(c + 5, 2); push_rgb(c + 7, 12'hFED);
        step(); pix_en = 1'b0;
        step(); step(); step();

        // Scan slot at (0,0) with both requesting: pointer (last = writer 0) unchanged by the stall.
        CounterX = 10'd0; CounterY = 10'd0; pix_en = 1'b1;
        wr_req = 2'b11; wr_addr0 = 15'd400; wr_data0 = 12'h400; wr_addr1 = 15'd500; wr_data1 = 12'h500;
        d = cyc;
        push_rd(d + 1, 0); exp_fs_q.push_back(d + 1);
        push_ack(d + 2, 3'b100); push_wr(d + 2, 500, 12'h500);
        push_ack(d + 3, 3'b010); push_wr(d + 3, 400, 12'h400);
        push_rgb(d + 3, 12'h0F0);
        step(); pix_en = 1'b0;
        step(); wr_req = 2'b01;
        step(); wr_req = 2'b00;
        step(); step(); step();

        // Out of range (19200) acked with error and no RAM access; 19199 is the last legal address.
        inDisplayArea = 1'b0;
        wr_req = 2'b01; wr_addr0 = 15'd19200; wr_data0 = 12'hEEE;
        e = cyc;
        push_ack(e + 1, 3'b011);
        step(); wr_req = 2'b00;
        step();
        wr_req = 2'b01; wr_addr0 = 15'd19199; wr_data0 = 12'h777;
        push_ack(e + 3, 3'b010); push_wr(e + 3, 19199, 12'h777);
        step(); wr_req = 2'b00;
        step();

        // Lone writer 1 is granted back-to-back.
        wr_req = 2'b10;
        f = cyc;
        for (int j = 0; j < 3; j++) begin
            wr_addr1 = ADDR_W'(600 + j); wr_data1 = 12'(12'h600 + j);
            push_ack(f + j + 1, 3'b100);
            push_wr(f + j + 1, 600 + j, 12'h600 + j);
            step();
        end
        wr_req = 2'b00;
        step(); step();
`endif

        step(); step(); step();
        check("pending_writes", exp_wr_q.size(), 0);
        check("pending_reads", exp_rd_q.size(), 0);
        check("pending_acks", exp_ack_q.size(), 0);
        check("pending_rgb", exp_rgb_q.size(), 0);
        check("pending_frame_start", exp_fs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
